masked_sbox_layer_ctrl: RTL and testbench



---
 rtl/masked_sbox_layer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_masked_sbox_layer_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_layer_ctrl.sv
// masked_sbox_layer_ctrl
// Runs a full masked S-box layer (NIBBLES nibbles, SEC_ORDER+1 shares each)
// through one external masked S-box core with a fixed LATENCY.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a layer (accepted only while busy=0)
//   state_in       input shares; share s of nibble i at [(s*NIBBLES+i)*4 +: 4]
//   busy           layer in progress
//   done           one-cycle pulse when state_out is updated
//   state_out      result shares, same layout as state_in, held until next done
//   sbox_in        shares to the core; share s at [s*4 +: 4]
//   sbox_out       shares from the core, same layout as sbox_in
//   sbox_en        core clock-enable / fresh-randomness valid
//   fresh_req      copy of sbox_en
//
// Shares are only ever moved between slots of the same share index; they are
// never combined, so the block adds no leakage path between shares.
module masked_sbox_layer_ctrl #(
    parameter int unsigned SEC_ORDER = 3,
    parameter int unsigned NIBBLES   = 16,
    parameter int unsigned LATENCY   = 11,
    parameter int unsigned PIPELINED = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [4*NIBBLES*(SEC_ORDER+1)-1:0]   state_in,
    output logic                                 busy,
    output logic                                 done,
    output logic [4*NIBBLES*(SEC_ORDER+1)-1:0]   state_out,
    output logic [4*(SEC_ORDER+1)-1:0]           sbox_in,
    input  logic [4*(SEC_ORDER+1)-1:0]           sbox_out,
    output logic                                 sbox_en,
    output logic                                 fresh_req
);

    localparam int unsigned D   = SEC_ORDER + 1;
    localparam int unsigned SW  = 4 * D;
    localparam int unsigned STW = 4 * NIBBLES * D;
    localparam int unsigned NW  = $clog2(NIBBLES) + 1;
    localparam int unsigned LW  = $clog2(LATENCY) + 1;
    localparam int unsigned IW  = $clog2(NIBBLES + 1) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [STW-1:0]   in_buf;
    logic [STW-1:0]   res_buf;
    logic [NW-1:0]    nib_cnt;   // result slot captured next
    logic [LW-1:0]    lat_cnt;   // cycles spent waiting on the core
    logic [IW-1:0]    iss_cnt;   // nibble on sbox_in this cycle (pipelined mode)

    logic             capture;
    logic             last_capture;
    logic [STW-1:0]   res_merged;
    logic [SW-1:0]    sbox_in_next;
    logic [LW-1:0]    lat_next;

    // Gather all shares of nibble k; out-of-range k yields an idle (zero) bus.
    function automatic logic [SW-1:0] pick(input logic [STW-1:0] v, input int unsigned k);
        logic [SW-1:0] r;
        r = '0;
        if (k < NIBBLES) begin
            for (int unsigned s = 0; s < D; s++) begin
                r[s*4 +: 4] = v[(s*NIBBLES + k)*4 +: 4];
            end
        end
        return r;
    endfunction

    // Capture decision, merged result buffer and next bus value.
    always_comb begin
        capture      = 1'b0;
        last_capture = 1'b0;
        if (state_q == RUN && lat_cnt == LW'(LATENCY - 1)) begin
            capture      = 1'b1;
            last_capture = (nib_cnt == NW'(NIBBLES - 1));
        end

        res_merged = res_buf;
        for (int unsigned s = 0; s < D; s++) begin
            res_merged[(s*NIBBLES + 32'(nib_cnt))*4 +: 4] = sbox_out[s*4 +: 4];
        end

        sbox_in_next = sbox_in;
        lat_next     = lat_cnt + LW'(1);
        if (PIPELINED != 0) begin
            // One nibble per cycle, then an idle bus while the core drains.
            sbox_in_next = pick(in_buf, 32'(iss_cnt) + 32'd1);
            if (lat_cnt == LW'(LATENCY - 1)) begin
                lat_next = lat_cnt;
            end
        end else if (capture) begin
            // Hold each nibble for LATENCY cycles, advance after its capture.
            sbox_in_next = pick(in_buf, 32'(nib_cnt) + 32'd1);
            lat_next     = '0;
        end
    end

    // Sequencer: state register, counters, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sbox_en   <= 1'b0;
            fresh_req <= 1'b0;
            sbox_in   <= '0;
            state_out <= '0;
            in_buf    <= '0;
            res_buf   <= '0;
            nib_cnt   <= '0;
            lat_cnt   <= '0;
            iss_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_buf    <= state_in;
                        sbox_in   <= pick(state_in, 0);
                        busy      <= 1'b1;
                        sbox_en   <= 1'b1;
                        fresh_req <= 1'b1;
                        nib_cnt   <= '0;
                        lat_cnt   <= '0;
                        iss_cnt   <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        res_buf <= res_merged;
                    end
                    if (last_capture) begin
                        // Final slot goes straight to state_out with the rest.
                        state_out <= res_merged;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        sbox_en   <= 1'b0;
                        fresh_req <= 1'b0;
                        sbox_in   <= '0;
                        nib_cnt   <= '0;
                        lat_cnt   <= '0;
                        iss_cnt   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        sbox_in <= sbox_in_next;
                        lat_cnt <= lat_next;
                        if (capture) begin
                            nib_cnt <= nib_cnt + NW'(1);
                        end
                        if (iss_cnt < IW'(NIBBLES)) begin
                            iss_cnt <= iss_cnt + IW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_sbox_layer_ctrl.sv
// Bench for masked_sbox_layer_ctrl: three instances (sequential, pipelined,
// single-nibble/latency-1) driven by behavioural Skinny-64 S-box cores.
module tb_masked_sbox_layer_ctrl;

    localparam int unsigned N = 16;
    localparam int unsigned L = 11;
    localparam logic [3:0] SB_T [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                         4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, start1, start2;
    logic [255:0] state_in0, state_in1;
    logic [15:0]  state_in2;
    logic         busy0, busy1, busy2, done0, done1, done2;
    logic [255:0] state_out0, state_out1;
    logic [15:0]  state_out2;
    logic [15:0]  sbox_in0, sbox_in1, sbox_in2, sbox_out0, sbox_out1, sbox_out2;
    logic         sbox_en0, sbox_en1, sbox_en2, fresh_req0, fresh_req1, fresh_req2;

    masked_sbox_layer_ctrl #(.SEC_ORDER(3), .NIBBLES(16), .LATENCY(11), .PIPELINED(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .state_in(state_in0), .busy(busy0),
        .done(done0), .state_out(state_out0), .sbox_in(sbox_in0), .sbox_out(sbox_out0),
        .sbox_en(sbox_en0), .fresh_req(fresh_req0));
    masked_sbox_layer_ctrl #(.SEC_ORDER(3), .NIBBLES(16), .LATENCY(11), .PIPELINED(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .state_in(state_in1), .busy(busy1),
        .done(done1), .state_out(state_out1), .sbox_in(sbox_in1), .sbox_out(sbox_out1),
        .sbox_en(sbox_en1), .fresh_req(fresh_req1));
    masked_sbox_layer_ctrl #(.SEC_ORDER(3), .NIBBLES(1), .LATENCY(1), .PIPELINED(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .state_in(state_in2), .busy(busy2),
        .done(done2), .state_out(state_out2), .sbox_in(sbox_in2), .sbox_out(sbox_out2),
        .sbox_en(sbox_en2), .fresh_req(fresh_req2));

    int checks = 0;
    int failures = 0;
    logic [63:0] sbq[$];

    function automatic logic [3:0] rc(input logic [15:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8] ^ v[15:12];
    endfunction

    function automatic logic [15:0] core_out(input logic [3:0] x, input logic [3:0] a,
                                             input logic [3:0] b, input logic [3:0] c);
        return {c, b, a, SB_T[x] ^ a ^ b ^ c};
    endfunction

    function automatic logic [15:0] nib(input logic [255:0] v, input int k);
        logic [15:0] r;
        for (int s = 0; s < 4; s++) r[s*4 +: 4] = v[(s*16 + k)*4 +: 4];
        return r;
    endfunction

    function automatic logic [63:0] recomb(input logic [255:0] v);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = rc(nib(v, i));
        return r;
    endfunction

    // Behavioural cores: output in cycle c is S(input of cycle c-L+1), re-masked.
    logic       rand_core;
    logic [3:0] m1, m2, m3;
    logic [3:0] dl0 [10];
    logic [3:0] dl1 [10];
    always @(posedge clk) begin
        {m1, m2, m3} <= rand_core ? 12'($urandom) : 12'd0;
        dl0[0] <= rc(sbox_in0);
        dl1[0] <= rc(sbox_in1);
        for (int j = 1; j < 10; j++) begin
            dl0[j] <= dl0[j-1];
            dl1[j] <= dl1[j-1];
        end
    end
    assign sbox_out0 = core_out(dl0[9], m1, m2, m3);
    assign sbox_out1 = core_out(dl1[9], m1, m2, m3);
    assign sbox_out2 = core_out(rc(sbox_in2), m1, m2, m3);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 16-nibble layer on dut0 (sel=0) or dut1 (sel=1); abort adds restart+reset.
    task automatic run_layer(input bit sel, input bit rnd, input bit abort);
        logic [255:0] vec, vec_alt;
        logic [63:0]  expv, got;
        logic [11:0]  m;
        logic [15:0]  exp_in;
        logic         b, d, e, f, act;
        logic [15:0]  si;
        logic [255:0] so;
        int done_c, last;
        for (int i = 0; i < 16; i++) begin
            m = rnd ? 12'($urandom) : 12'd0;
            vec[(0*16 + i)*4 +: 4] = 4'(i) ^ m[3:0] ^ m[7:4] ^ m[11:8];
            vec[(1*16 + i)*4 +: 4] = m[3:0];
            vec[(2*16 + i)*4 +: 4] = m[7:4];
            vec[(3*16 + i)*4 +: 4] = m[11:8];
            expv[i*4 +: 4] = SB_T[i];
        end
        for (int w = 0; w < 8; w++) vec_alt[w*32 +: 32] = $urandom;
        done_c = sel ? int'(N + L) : int'(N * L + 1);
        last = abort ? 200 : done_c + 3;
        rand_core = rnd;
        if (!abort) sbq.push_back(expv);
        @(negedge clk);
        if (sel) begin state_in1 = vec; start1 = 1'b1; end
        else     begin state_in0 = vec; start0 = 1'b1; end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            b  = sel ? busy1 : busy0;
            d  = sel ? done1 : done0;
            e  = sel ? sbox_en1 : sbox_en0;
            f  = sel ? fresh_req1 : fresh_req0;
            si = sel ? sbox_in1 : sbox_in0;
            so = sel ? state_out1 : state_out0;
            act = (abort && c > 50) ? 1'b0 : (c < done_c);
            exp_in = 16'd0;
            if (act) exp_in = sel ? ((c <= int'(N)) ? nib(vec, c - 1) : 16'd0) : nib(vec, (c - 1) / int'(L));
            chk("busy", 256'(b), 256'(act));
            chk("done", 256'(d), 256'(!abort && c == done_c));
            chk("sbox_en", 256'(e), 256'(act));
            chk("fresh_req", 256'(f), 256'(act));
            chk("sbox_in", 256'(si), 256'(exp_in));
            if (d && sbq.size() > 0) begin
                got = sbq.pop_front();
                chk("state_out_recomb", 256'(recomb(so)), 256'(got));
                if (!rnd) chk("state_out_exact", so, 256'(got));
            end
            if (abort && c == 51) chk("abort_state_out", so, 256'd0);
            if (c == 1 || (abort && c == 21)) begin
                start0 = 1'b0; start1 = 1'b0;
                state_in0 = vec_alt; state_in1 = vec_alt;
            end
            if (abort && c == 20) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
                state_in0 = ~vec; state_in1 = ~vec;
            end
            if (abort && c == 50) rst = 1'b1;
            if (abort && c == 51) rst = 1'b0;
        end
        chk("sb_empty", 256'(sbq.size()), 256'd0);
    endtask

    initial begin
        logic [15:0] va, vb, exp_in2;
        logic [11:0] m;
        logic [63:0] got;
        rst = 1'b1; rand_core = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        state_in0 = '0; state_in1 = '0; state_in2 = '0;
        repeat (12) @(negedge clk);
        chk("rst_busy", 256'({busy0, busy1, busy2}), 256'd0);
        chk("rst_done", 256'({done0, done1, done2}), 256'd0);
        chk("rst_en", 256'({sbox_en0, sbox_en1, sbox_en2, fresh_req0, fresh_req1, fresh_req2}), 256'd0);
        chk("rst_sbox_in", 256'({sbox_in0, sbox_in1, sbox_in2}), 256'd0);
        chk("rst_state_out0", state_out0, 256'd0);
        chk("rst_state_out1", state_out1, 256'd0);
        chk("rst_state_out2", 256'(state_out2), 256'd0);
        rst = 1'b0;

        run_layer(1'b0, 1'b0, 1'b0);   // plain shares, sequential core
        run_layer(1'b0, 1'b1, 1'b0);   // random masks, randomised core
        run_layer(1'b1, 1'b0, 1'b0);   // pipelined core
        run_layer(1'b0, 1'b0, 1'b1);   // ignored restart, then mid-run reset

        // Single nibble, latency 1, back-to-back layers.
        rand_core = 1'b1;
        va = 16'h000A;
        m  = 12'($urandom);
        vb = {m, 4'h7 ^ m[3:0] ^ m[7:4] ^ m[11:8]};
        sbq.push_back(64'h5);
        @(negedge clk);
        state_in2 = va; start2 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_in2 = (c == 1) ? va : ((c == 3) ? vb : 16'd0);
            chk("s5_busy", 256'(busy2), 256'(c == 1 || c == 3));
            chk("s5_done", 256'(done2), 256'(c == 2 || c == 4));
            chk("s5_sbox_en", 256'(sbox_en2), 256'(c == 1 || c == 3));
            chk("s5_fresh_req", 256'(fresh_req2), 256'(c == 1 || c == 3));
            chk("s5_sbox_in", 256'(sbox_in2), 256'(exp_in2));
            if (done2 && sbq.size() > 0) begin
                got = sbq.pop_front();
                chk("s5_state_out", 256'(rc(state_out2)), 256'(got));
            end
            if (c == 3) chk("s5_hold", 256'(rc(state_out2)), 256'h5);
            if (c == 1) begin start2 = 1'b0; state_in2 = 16'hFFFF; end
            if (c == 2) begin start2 = 1'b1; state_in2 = vb; sbq.push_back(64'hB); end
            if (c == 3) begin start2 = 1'b0; state_in2 = 16'h1234; end
        end
        chk("s5_sb_empty", 256'(sbq.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
